ysyx_210544_wb_stage: RTL and testbench

- Write-back stage, directly downstream of the memory stage. Consumes the memory stage's memoryed req/ack handshake.
- Captures the result bundle, drives the single register-file write port for one cycle, and emits a one-cycle commit pulse.
- Maintains a retired-instruction counter and signals completion back to the fetch side via a writebacked req/ack handshake.
- Non-pipelined: one instruction in flight at a time.

---
 rtl/ysyx_210544_wb_stage.sv | 125 ++++++++++++
 tb/tb_ysyx_210544_wb_stage.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ysyx_210544_wb_stage.sv
// Write-back stage: one instruction in flight, single regfile write port, commit pulse, retired counter.
// Optional operand-forwarding outputs are enabled by defining YSYX_210544_WB_FWD_EN.
module ysyx_210544_wb_stage #(
  parameter int INSTRET_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_wb_memoryed_req,
  output logic                 o_wb_memoryed_ack,
  output logic                 o_wb_writebacked_req,
  input  logic                 i_wb_writebacked_ack,
  input  logic [63:0]          i_wb_pc,
  input  logic [31:0]          i_wb_inst,
  input  logic [4:0]           i_wb_rd,
  input  logic                 i_wb_rd_wen,
  input  logic [63:0]          i_wb_rd_wdata,
  input  logic                 i_wb_nocmt,
  input  logic                 i_wb_skipcmt,
  input  logic [31:0]          i_wb_intrNo,
  output logic [4:0]           o_wb_rd,
  output logic                 o_wb_rd_wen,
  output logic [63:0]          o_wb_rd_wdata,
  output logic                 o_wb_cmt_valid,
  output logic [63:0]          o_wb_cmt_pc,
  output logic [31:0]          o_wb_cmt_inst,
  output logic                 o_wb_cmt_skip,
  output logic [31:0]          o_wb_intrNo,
  output logic [INSTRET_W-1:0] o_wb_instret
`ifdef YSYX_210544_WB_FWD_EN
  ,
  output logic                 o_wb_fwd_valid,
  output logic [4:0]           o_wb_fwd_rd,
  output logic [63:0]          o_wb_fwd_data
`endif
);

  // state | meaning
  // IDLE  | ready to accept a result from the memory stage
  // WRITE | regfile write + commit pulse, completion offered to fetch
  // WAIT  | completion still pending, no further writes or commits
  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, WAIT = 2'd2} state_e;

  state_e                 state_q, state_d;
  logic [63:0]            pc_q;
  logic [31:0]            inst_q;
  logic [4:0]             rd_q;
  logic                   rd_wen_q;
  logic [63:0]            rd_wdata_q;
  logic                   nocmt_q;
  logic                   skipcmt_q;
  logic [31:0]            intr_q;
  logic [INSTRET_W-1:0]   instret_q, instret_d;

  logic mem_hs;
  logic wb_hs;
  logic rd_write;

  assign o_wb_memoryed_ack    = (state_q == IDLE);
  assign o_wb_writebacked_req = (state_q != IDLE);
  assign mem_hs   = i_wb_memoryed_req & o_wb_memoryed_ack;
  assign wb_hs    = o_wb_writebacked_req & i_wb_writebacked_ack;
  assign rd_write = rd_wen_q & (rd_q != 5'd0);

  always_comb begin
    state_d   = state_q;
    instret_d = instret_q;
    case (state_q)
      IDLE:    if (mem_hs) state_d = WRITE;
      WRITE: begin
        state_d = i_wb_writebacked_ack ? IDLE : WAIT;
        if (!nocmt_q) instret_d = instret_q + {{(INSTRET_W-1){1'b0}}, 1'b1};
      end
      WAIT:    if (i_wb_writebacked_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= 64'd0;
      inst_q     <= 32'd0;
      rd_q       <= 5'd0;
      rd_wen_q   <= 1'b0;
      rd_wdata_q <= 64'd0;
      nocmt_q    <= 1'b0;
      skipcmt_q  <= 1'b0;
      intr_q     <= 32'd0;
      instret_q  <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
      if (mem_hs) begin
        pc_q       <= i_wb_pc;
        inst_q     <= i_wb_inst;
        rd_q       <= i_wb_rd;
        rd_wen_q   <= i_wb_rd_wen;
        rd_wdata_q <= i_wb_rd_wdata;
        nocmt_q    <= i_wb_nocmt;
        skipcmt_q  <= i_wb_skipcmt;
        intr_q     <= i_wb_intrNo;
      end else if (wb_hs) begin
        intr_q <= 32'd0;
      end
    end
  end

  // Write and commit strobes are confined to the single WRITE cycle.
  assign o_wb_rd_wen    = (state_q == WRITE) & rd_write;
  assign o_wb_cmt_valid = (state_q == WRITE) & ~nocmt_q;
  assign o_wb_rd        = rd_q;
  assign o_wb_rd_wdata  = rd_wdata_q;
  assign o_wb_cmt_pc    = pc_q;
  assign o_wb_cmt_inst  = inst_q;
  assign o_wb_cmt_skip  = skipcmt_q;
  assign o_wb_intrNo    = intr_q;
  assign o_wb_instret   = instret_q;

`ifdef YSYX_210544_WB_FWD_EN
  assign o_wb_fwd_valid = (state_q != IDLE) & rd_write;
  assign o_wb_fwd_rd    = rd_q;
  assign o_wb_fwd_data  = rd_wdata_q;
`endif

endmodule

// File: tb/tb_ysyx_210544_wb_stage.sv
// Directed bench for the write-back stage; a 4-bit retired counter makes wrap-around reachable.
module tb_ysyx_210544_wb_stage;
  localparam int W = 4;

  logic         clk, rst;
  logic         mem_req, mem_ack, wb_req, wb_ack;
  logic [63:0]  pc, wdata;
  logic [31:0]  inst, intr;
  logic [4:0]   rd;
  logic         wen, nocmt, skip;
  logic [4:0]   o_rd;
  logic         o_wen, o_cmt, o_skip;
  logic [63:0]  o_wdata, o_pc;
  logic [31:0]  o_inst, o_intr;
  logic [W-1:0] o_instret;
`ifdef YSYX_210544_WB_FWD_EN
  logic         f_valid;
  logic [4:0]   f_rd;
  logic [63:0]  f_data;
`endif

  int checks = 0;
  int errors = 0;

  ysyx_210544_wb_stage #(.INSTRET_W(W)) dut (
    .clk(clk), .rst(rst),
    .i_wb_memoryed_req(mem_req), .o_wb_memoryed_ack(mem_ack),
    .o_wb_writebacked_req(wb_req), .i_wb_writebacked_ack(wb_ack),
    .i_wb_pc(pc), .i_wb_inst(inst), .i_wb_rd(rd), .i_wb_rd_wen(wen),
    .i_wb_rd_wdata(wdata), .i_wb_nocmt(nocmt), .i_wb_skipcmt(skip),
    .i_wb_intrNo(intr),
    .o_wb_rd(o_rd), .o_wb_rd_wen(o_wen), .o_wb_rd_wdata(o_wdata),
    .o_wb_cmt_valid(o_cmt), .o_wb_cmt_pc(o_pc), .o_wb_cmt_inst(o_inst),
    .o_wb_cmt_skip(o_skip), .o_wb_intrNo(o_intr), .o_wb_instret(o_instret)
`ifdef YSYX_210544_WB_FWD_EN
    , .o_wb_fwd_valid(f_valid), .o_wb_fwd_rd(f_rd), .o_wb_fwd_data(f_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [63:0] p, input logic [4:0] r, input logic we,
                       input logic [63:0] d, input logic nc, input logic [31:0] it);
    mem_req = 1'b1; pc = p; rd = r; wen = we; wdata = d; nocmt = nc; intr = it;
    inst = p[31:0] ^ 32'h0000_0013;
  endtask

  initial begin
    rst = 1'b1; mem_req = 0; wb_ack = 1; pc = 0; inst = 0; rd = 0; wen = 0;
    wdata = 0; nocmt = 0; skip = 0; intr = 0;
    step(); step();
    check("rst_ack", mem_ack, 1);
    check("rst_wbreq", wb_req, 0);
    rst = 1'b0;
    step();
    check("init_ack", mem_ack, 1);
    check("init_wbreq", wb_req, 0);
    check("init_instret", o_instret, 0);
    check("init_wen", o_wen, 0);
    check("init_cmt", o_cmt, 0);

    // basic write with immediate completion
    drive(64'h8000_0000, 5'd5, 1, 64'hDEAD_BEEF, 0, 0);
    skip = 1'b1;
    step();
    mem_req = 0; skip = 0;
    check("w1_wen", o_wen, 1);
    check("w1_rd", o_rd, 5);
    check("w1_wdata", o_wdata, 64'hDEAD_BEEF);
    check("w1_cmt", o_cmt, 1);
    check("w1_pc", o_pc, 64'h8000_0000);
    check("w1_inst", o_inst, 32'h8000_0013);
    check("w1_skip", o_skip, 1);
    check("w1_wbreq", wb_req, 1);
    check("w1_ack", mem_ack, 0);
    check("w1_instret0", o_instret, 0);
    step();
    check("w1_instret1", o_instret, 1);
    check("w1_ack_back", mem_ack, 1);
    check("w1_wen_off", o_wen, 0);
    check("w1_cmt_off", o_cmt, 0);

    // rd = 0 must not write but still commits
    drive(64'h8000_0004, 5'd0, 1, 64'h1234, 0, 0);
    step();
    mem_req = 0;
    check("x0_wen", o_wen, 0);
    check("x0_cmt", o_cmt, 1);
    step();
    check("x0_instret", o_instret, 2);

    // bubble: no commit, no count
    drive(64'h8000_0008, 5'd3, 1, 64'h77, 1, 0);
    step();
    mem_req = 0;
    check("nc_cmt", o_cmt, 0);
    step();
    check("nc_instret", o_instret, 2);

    // completion stalled for 4 cycles, competing request ignored
    wb_ack = 0;
    drive(64'h1000, 5'd7, 1, 64'hAA, 0, 32'd7);
    step();
    check("st_wen", o_wen, 1);
    check("st_cmt", o_cmt, 1);
    check("st_intr", o_intr, 7);
    drive(64'h2000, 5'd8, 1, 64'hBB, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("st_wait_wen", o_wen, 0);
      check("st_wait_cmt", o_cmt, 0);
      check("st_wait_wbreq", wb_req, 1);
      check("st_wait_ack", mem_ack, 0);
      check("st_wait_pc", o_pc, 64'h1000);
    end
    check("st_instret", o_instret, 3);
    wb_ack = 1;
    step();
    check("st_idle_ack", mem_ack, 1);
    check("st_intr_clr", o_intr, 0);
    check("st_pc_hold", o_pc, 64'h1000);
    step();
    mem_req = 0;
    check("st_next_pc", o_pc, 64'h2000);
    check("st_next_rd", o_rd, 8);
    step();
    check("st_next_instret", o_instret, 4);

    // wrap the 4-bit counter: 11 commits to 15, one more to 0
    for (int i = 0; i < 11; i++) begin
      drive(64'h4000 + 64'(i), 5'd1, 1, 64'(i), 0, 0);
      step();
      mem_req = 0;
      step();
    end
    check("wrap_15", o_instret, 15);
    drive(64'h5000, 5'd1, 1, 64'h1, 0, 0);
    step();
    mem_req = 0;
    step();
    check("wrap_0", o_instret, 0);

    // async reset while waiting for completion
    wb_ack = 0;
    drive(64'h6000, 5'd4, 1, 64'h66, 0, 32'd3);
    step();
    mem_req = 0;
    step();
    check("rw_wbreq", wb_req, 1);
    check("rw_instret", o_instret, 1);
    rst = 1'b1;
    #1;
    check("rw_wbreq0", wb_req, 0);
    check("rw_ack1", mem_ack, 1);
    check("rw_instret0", o_instret, 0);
    check("rw_pc0", o_pc, 0);
    check("rw_intr0", o_intr, 0);
    step();
    rst = 1'b0;
    wb_ack = 1;
    check("rw_post_wen", o_wen, 0);
    check("rw_post_cmt", o_cmt, 0);
    drive(64'h3000, 5'd9, 1, 64'h55, 0, 0);
    step();
    mem_req = 0;
    check("rr_wen", o_wen, 1);
    check("rr_rd", o_rd, 9);
    check("rr_wdata", o_wdata, 64'h55);
    check("rr_cmt", o_cmt, 1);
    step();
    check("rr_instret", o_instret, 1);
    check("rr_ack", mem_ack, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
